// File: rtl/imem_responder_pkg.sv
// Shared constants for the instruction-memory responder.
// FSM encodings and RV32I opcode/NOP definitions.
package imem_responder_pkg;

  localparam logic [1:0] IMEM_S_LOAD  = 2'd0;
  localparam logic [1:0] IMEM_S_RUN   = 2'd1;
  localparam logic [1:0] IMEM_S_DRAIN = 2'd2;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_NOP    = OPCODE_OP_IMM;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_WORD = {25'd0, OPCODE_NOP};

endpackage

// File: rtl/imem_responder_if.sv
// Loader and fetch bus of the instruction-memory responder.
// master = loader/CPU side, slave = responder.
interface imem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              load_start;
  logic              load_done;
  logic              load_valid;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_err;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  modport master (
    output load_start, load_done, load_valid,
    output load_addr, load_data,
    input  load_err,
    output req_valid, req_addr,
    input  req_ready,
    input  resp_valid, resp_data, resp_err,
    output resp_ready
  );

  modport slave (
    input  load_start, load_done, load_valid,
    input  load_addr, load_data,
    output load_err,
    input  req_valid, req_addr,
    output req_ready,
    output resp_valid, resp_data, resp_err,
    input  resp_ready
  );
endinterface

// File: rtl/imem_responder_ram.sv
// imem_ram: single-port synchronous RAM, registered read.
// IMEM_PARITY_EN adds one stored parity bit per word.
module imem_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef IMEM_PARITY_EN
  input  logic              wpar,
  output logic              rpar,
`endif
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef IMEM_PARITY_EN
  logic              par [DEPTH];
`endif

  // array write, contents never reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
`ifdef IMEM_PARITY_EN
      par[addr] <= wpar;
`endif
    end
  end

  // read register, holds its value until the next read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
`ifdef IMEM_PARITY_EN
      rpar  <= 1'b0;
`endif
    end else if (re) begin
      rdata <= mem[addr];
`ifdef IMEM_PARITY_EN
      rpar  <= par[addr];
`endif
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: load port + fetch handshake.
// Optional IMEM_PARITY_EN: per-word even parity, inject_parity.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic reset,
`ifdef IMEM_PARITY_EN
  input  logic inject_parity,
`endif
  imem_responder_if.slave bus,
  output logic mode_run
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state;
  logic [1:0]        state_n;
  logic              accept;
  logic              ld_range;
  logic              rq_range;
  logic              we;
  logic              re;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] rdata;
  logic              oor_q;
  logic              bad;

  assign ld_range = {1'b0, bus.load_addr} < DEPTH_L;
  assign rq_range = {1'b0, bus.req_addr} < DEPTH_L;
  assign mode_run = (state == IMEM_S_RUN);

  // accept only in RUN, never in the cycle load_start arrives
  always_comb begin
    bus.req_ready = 1'b0;
    if (state == IMEM_S_RUN && !bus.load_start)
      bus.req_ready = !bus.resp_valid || bus.resp_ready;
  end

  assign accept = bus.req_valid && bus.req_ready;
  assign we = (state == IMEM_S_LOAD) && bus.load_valid && ld_range;
  assign re = accept && rq_range;
  assign ram_addr = (state == IMEM_S_LOAD) ? bus.load_addr[AW-1:0]
                                           : bus.req_addr[AW-1:0];

  // mode transitions; done wins in LOAD, start wins in RUN
  always_comb begin
    state_n = state;
    case (state)
      IMEM_S_LOAD:
        if (bus.load_done) state_n = IMEM_S_RUN;
      IMEM_S_RUN:
        if (bus.load_start) state_n = IMEM_S_DRAIN;
      IMEM_S_DRAIN:
        if (!bus.resp_valid || bus.resp_ready) state_n = IMEM_S_LOAD;
      default: state_n = IMEM_S_LOAD;
    endcase
  end

  // state, response-valid and error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IMEM_S_LOAD;
      bus.resp_valid <= 1'b0;
      oor_q          <= 1'b0;
      bus.load_err   <= 1'b0;
    end else begin
      state        <= state_n;
      bus.load_err <= bus.load_valid &&
                      (state != IMEM_S_LOAD || !ld_range);
      if (accept) begin
        bus.resp_valid <= 1'b1;
        oor_q          <= !rq_range;
      end else if (bus.resp_ready) begin
        bus.resp_valid <= 1'b0;
      end
    end
  end

`ifdef IMEM_PARITY_EN
  logic wpar;
  logic rpar;
  logic rd_q;

  assign wpar = ^bus.load_data ^ inject_parity;

  // remembers that the held word came from the array
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       rd_q <= 1'b0;
    else if (accept) rd_q <= rq_range;
  end

  assign bad = oor_q || (rd_q && (^{rdata, rpar}));
`else
  assign bad = oor_q;
`endif

  imem_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .re    (re),
    .addr  (ram_addr),
    .wdata (bus.load_data),
`ifdef IMEM_PARITY_EN
    .wpar  (wpar),
    .rpar  (rpar),
`endif
    .rdata (rdata)
  );

  assign bus.resp_err  = bad;
  assign bus.resp_data = bad ? DATA_W'(NOP_WORD) : rdata;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder (DEPTH = 128).
// Parity steps run when IMEM_PARITY_EN is defined.
module tb_imem_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mode_run;
`ifdef IMEM_PARITY_EN
  logic inject_parity = 1'b0;
`endif
  int checks = 0;
  int errors = 0;

  imem_responder_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  imem_responder #(
    .ADDR_W (8),
    .DEPTH  (128),
    .DATA_W (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef IMEM_PARITY_EN
    .inject_parity (inject_parity),
`endif
    .bus           (bus.slave),
    .mode_run      (mode_run)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] a,
                      input logic [31:0] d);
    bus.load_valid = 1'b1;
    bus.load_addr  = a;
    bus.load_data  = d;
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic fetch(input string tag,
                       input logic [7:0] a,
                       input logic [31:0] d,
                       input logic e);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    tick();
    bus.req_valid = 1'b0;
    chk({tag, "_v"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, "_d"}, bus.resp_data, d);
    chk({tag, "_e"}, 32'(bus.resp_err), 32'(e));
  endtask

  task automatic go_run();
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
  endtask

  initial begin
    bus.load_start = 0;
    bus.load_done  = 0;
    bus.load_valid = 0;
    bus.load_addr  = 0;
    bus.load_data  = 0;
    bus.req_valid  = 0;
    bus.req_addr   = 0;
    bus.resp_ready = 0;

    // reset values
    tick();
    tick();
    chk("rst_rdy", 32'(bus.req_ready), 0);
    chk("rst_rv", 32'(bus.resp_valid), 0);
    chk("rst_rd", bus.resp_data, 0);
    chk("rst_re", 32'(bus.resp_err), 0);
    chk("rst_le", 32'(bus.load_err), 0);
    chk("rst_mr", 32'(mode_run), 0);
    reset = 1'b0;

    // load 0..3 and start serving
    load(0, 32'h11111111);
    load(1, 32'h22222222);
    load(2, 32'h33333333);
    load(3, 32'h44444444);
    chk("ld_le", 32'(bus.load_err), 0);
    chk("ld_rdy", 32'(bus.req_ready), 0);
    go_run();
    chk("run_mr", 32'(mode_run), 1);
    chk("run_rdy", 32'(bus.req_ready), 1);

    // back-to-back fetches
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 0;
    tick();
    chk("b2b0", bus.resp_data, 32'h11111111);
    bus.req_addr = 1;
    tick();
    chk("b2b1_v", 32'(bus.resp_valid), 1);
    chk("b2b1", bus.resp_data, 32'h22222222);
    bus.req_addr = 2;
    tick();
    chk("b2b2", bus.resp_data, 32'h33333333);
    bus.req_addr = 3;
    tick();
    chk("b2b3_v", 32'(bus.resp_valid), 1);
    chk("b2b3", bus.resp_data, 32'h44444444);
    chk("b2b3_e", 32'(bus.resp_err), 0);
    bus.req_valid = 1'b0;
    tick();
    chk("b2b_idle", 32'(bus.resp_valid), 0);

    // backpressure
    bus.resp_ready = 1'b0;
    fetch("bp", 2, 32'h33333333, 0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rdy", 32'(bus.req_ready), 0);
      tick();
      chk("bp_hold", bus.resp_data, 32'h33333333);
      chk("bp_v", 32'(bus.resp_valid), 1);
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(bus.req_ready), 1);
    tick();
    chk("bp_next", bus.resp_data, 32'h22222222);
    bus.req_valid = 1'b0;
    tick();

    // out-of-range fetch and loads in RUN
    fetch("oor", 255, 32'h00000013, 1);
    tick();
    load(200, 32'hFFFFFFFF);
    chk("ld200_le", 32'(bus.load_err), 1);
    load(1, 32'hBADBADBA);
    chk("ldrun_le", 32'(bus.load_err), 1);
    tick();
    chk("le_pulse", 32'(bus.load_err), 0);
    fetch("keep1", 1, 32'h22222222, 0);
    tick();

    // drain with a stalled response
    bus.resp_ready = 1'b0;
    fetch("dr", 3, 32'h44444444, 0);
    bus.req_valid  = 1'b1;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    chk("dr_mr", 32'(mode_run), 0);
    chk("dr_rdy", 32'(bus.req_ready), 0);
    tick();
    chk("dr_hold", bus.resp_data, 32'h44444444);
    chk("dr_v", 32'(bus.resp_valid), 1);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    tick();
    chk("dr_done_v", 32'(bus.resp_valid), 0);
    chk("dr_load_mr", 32'(mode_run), 0);

    // reload in LOAD; out-of-range load errors
    load(0, 32'hDEADBEEF);
    chk("re_le", 32'(bus.load_err), 0);
    load(200, 32'h12345678);
    chk("re200_le", 32'(bus.load_err), 1);
`ifdef IMEM_PARITY_EN
    load(4, 32'h55555555);
    inject_parity = 1'b1;
    load(5, 32'h66666666);
    inject_parity = 1'b0;
`endif
    // start+done together in LOAD: done wins
    bus.load_start = 1'b1;
    go_run();
    bus.load_start = 1'b0;
    chk("sd_mr", 32'(mode_run), 1);
    fetch("beef", 0, 32'hDEADBEEF, 0);
    fetch("keep1b", 1, 32'h22222222, 0);
`ifdef IMEM_PARITY_EN
    fetch("par5", 5, 32'h00000013, 1);
    fetch("par4", 4, 32'h55555555, 0);
`endif
    tick();

    // start+done together in RUN: start wins
    bus.req_valid  = 1'b1;
    bus.req_addr   = 0;
    bus.load_start = 1'b1;
    bus.load_done  = 1'b1;
    #1;
    chk("st_rdy", 32'(bus.req_ready), 0);
    tick();
    bus.load_start = 1'b0;
    bus.load_done  = 1'b0;
    bus.req_valid  = 1'b0;
    chk("st_v", 32'(bus.resp_valid), 0);
    chk("st_mr", 32'(mode_run), 0);
    tick();
    go_run();

    // async reset mid-fetch
    bus.resp_ready = 1'b0;
    fetch("ar", 2, 32'h33333333, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_v", 32'(bus.resp_valid), 0);
    chk("ar_mr", 32'(mode_run), 0);
    chk("ar_d", bus.resp_data, 0);
    tick();
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    go_run();
    fetch("ar_m0", 0, 32'hDEADBEEF, 0);
    fetch("ar_m3", 3, 32'h44444444, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
